// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned N x N -> 2N multiplier. Each BUSY cycle
// shifts the multiplicand left, shifts the multiplier right, and adds when the multiplier LSB is set.
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [2*N-1:0] mcand, acc, sum;
  logic [N-1:0] mplier;
  logic [CW-1:0] cnt;
  logic last;
  assign last = (state == BUSY) && (cnt == CW'(N - 1));
  // The final product is taken from sum so the last iteration's add is included.
  assign sum = mplier[0] ? acc + mcand : acc;
  assign ready = (state == IDLE);
  assign busy = ~ready;
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = BUSY;
    else if (last) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= last;
      if (state == IDLE && start) begin
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == BUSY) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) product <= sum;
      end
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of reset, latency, boundaries, ignored start,
// back-to-back operation and mid-operation reset for the N=8 multiplier.
module tb_shift_add_multiplier;
  logic clk, rst, start, ready, busy, done;
  logic [7:0] a, b;
  logic [15:0] product;
  int checks = 0;
  int errors = 0;
  shift_add_multiplier #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string tag);
    int lat;
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    lat = 0;
    while (!done && lat < 20) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd8);
    chk({tag, " product"}, {16'd0, product}, {16'd0, exp});
    chk({tag, " ready at done"}, {31'd0, ready}, 32'd1);
    @(negedge clk);
    chk({tag, " done width"}, {31'd0, done}, 32'd0);
    chk({tag, " product hold"}, {16'd0, product}, {16'd0, exp});
  endtask
  initial begin
    int n_done, t1, t2;
    rst = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle outputs", {28'd0, ready, busy, done, |product}, 32'b1000);
    end
    run(8'd13, 8'd11, 16'd143, "13x11");
    repeat (3) @(negedge clk);
    chk("143 held", {16'd0, product}, 32'd143);
    run(8'd255, 8'd255, 16'd65025, "255x255");
    run(8'd0, 8'd200, 16'd0, "0x200");
    run(8'd1, 8'd173, 16'd173, "1x173");
    run(8'd128, 8'd2, 16'd256, "128x2");
    @(negedge clk);
    start = 1'b1; a = 8'd6; b = 8'd7;
    n_done = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        chk("ignored start product", {16'd0, product}, 32'd42);
      end
      start = (i == 3);
      a = (i == 3) ? 8'd9 : ~a;
      b = (i == 3) ? 8'd9 : ~b;
    end
    start = 1'b0;
    chk("ignored start done count", n_done, 32'd1);
    chk("ignored start idle", {31'd0, ready}, 32'd1);
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd5;
    n_done = 0; t1 = 1000; t2 = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      a = 8'd10; b = 8'd10;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          t1 = t;
          chk("b2b first product", {16'd0, product}, 32'd15);
        end else begin
          t2 = t;
          chk("b2b second product", {16'd0, product}, 32'd100);
        end
      end
      if (t == t1 + 1) start = 1'b0;
    end
    chk("b2b done count", n_done, 32'd2);
    chk("b2b spacing", t2 - t1, 32'd9);
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid-op busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid-op reset product", {16'd0, product}, 32'd0);
    chk("mid-op reset ready", {31'd0, ready}, 32'd1);
    chk("mid-op reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("aborted op no done", n_done, 32'd0);
    chk("aborted op product", {16'd0, product}, 32'd0);
    run(8'd7, 8'd9, 16'd63, "7x9");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
